// File: rtl/mmcm_phase_shift_ctrl_if.sv
// mmcm_phase_shift_ctrl_if
// Groups the phase command strobes, the MMCM dynamic phase-shift handshake
// (PSEN/PSINCDEC/PSDONE) and the status outputs of mmcm_phase_shift_ctrl.
// master: the side that commands targets and models the MMCM.
// slave : the controller itself.
`timescale 1ns/1ps

interface mmcm_phase_shift_ctrl_if #(
    parameter int POS_W = 16
);
    // Handshake semantics: target_load_i and step_req_i are single-cycle strobes
    // sampled on every rising clk_i edge with no back-pressure. psen_o is a
    // one-cycle request to the MMCM with psincdec_o valid in that same cycle and
    // held until the request completes; psdone_i is the one-cycle completion.
    // Only one request is ever outstanding, so psen_o is never re-asserted
    // before psdone_i (or a timeout / loss of lock) closes the previous one.
    logic [POS_W-1:0] target_pos_i;
    logic             target_load_i;
    logic             step_req_i;
    logic             step_dir_i;
    logic             psdone_i;
    logic             psen_o;
    logic             psincdec_o;
    logic [POS_W-1:0] cur_pos_o;
    logic             busy_o;
    logic             at_target_o;
    logic             error_o;
    logic [2:0]       state_dbg_o;

    modport master (
        output target_pos_i, target_load_i, step_req_i, step_dir_i, psdone_i,
        input  psen_o, psincdec_o, cur_pos_o, busy_o, at_target_o, error_o, state_dbg_o
    );

    modport slave (
        input  target_pos_i, target_load_i, step_req_i, step_dir_i, psdone_i,
        output psen_o, psincdec_o, cur_pos_o, busy_o, at_target_o, error_o, state_dbg_o
    );
endinterface

// File: rtl/mmcm_phase_shift_ctrl.sv
// mmcm_phase_shift_ctrl
// Walks the MMCM fine phase position to a commanded target, one PSEN per step,
// taking the shortest way round one output period (STEPS_PER_P positions).
// A missing PSDONE parks the FSM in ERR until a new target is loaded; loss of
// lock returns everything to position 0.
// Optional feature macro: PS_SETTLE_EN adds a SETTLE_CYC-cycle SETTLE state
// after every PSDONE before the next step decision.
`timescale 1ns/1ps

module mmcm_phase_shift_ctrl #(
    parameter int POS_W       = 16,
    parameter int STEPS_PER_P = 4480,
    parameter int DONE_TMO    = 64,
    parameter int SETTLE_CYC  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     locked_i,
    mmcm_phase_shift_ctrl_if.slave   ps_if
);

    // One extra bit so target-cur never overflows before the modulo fix-up.
    localparam int CW = POS_W + 1;
    localparam logic [CW-1:0]    P_EXT  = CW'(STEPS_PER_P);
    localparam logic [CW-1:0]    HALF   = CW'(STEPS_PER_P / 2);
    localparam logic [POS_W-1:0] P_LAST = POS_W'(STEPS_PER_P - 1);
    localparam int CNT_W = $clog2((DONE_TMO > SETTLE_CYC) ? DONE_TMO : SETTLE_CYC) + 1;
    // WAIT_DONE starts the cycle after PSEN, so the last allowed wait cycle
    // has the counter at DONE_TMO-2 and the error shows DONE_TMO cycles after PSEN.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(DONE_TMO - 2);
`ifdef PS_SETTLE_EN
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
`ifdef PS_SETTLE_EN
        S_SETTLE    = 3'd3,
`endif
        S_ERR       = 3'd4
    } state_t;

    state_t           r_state;
    logic [POS_W-1:0] r_target;
    logic [POS_W-1:0] r_cur_pos;
    logic [CNT_W-1:0] r_cnt;
    logic             r_psen;
    logic             r_incdec;
    logic             r_busy;
    logic             r_at_target;
    logic             r_error;

    logic [CW-1:0]    w_diff_raw;
    logic [CW-1:0]    w_dist;
    logic             w_go_inc;
    logic             w_load_ok;
    logic [POS_W-1:0] w_tgt_inc;
    logic [POS_W-1:0] w_tgt_dec;
    logic [POS_W-1:0] w_cur_inc;
    logic [POS_W-1:0] w_cur_dec;
    logic [POS_W-1:0] w_cur_step;
    logic [POS_W-1:0] w_target_nxt;

    // Forward distance to the target modulo one period; increment when that is
    // at most half a period, otherwise decrementing is shorter.
    assign w_diff_raw = {1'b0, r_target} - {1'b0, r_cur_pos};
    assign w_dist     = w_diff_raw[CW-1] ? (w_diff_raw + P_EXT) : w_diff_raw;
    assign w_go_inc   = (w_dist <= HALF);

    assign w_load_ok  = ps_if.target_load_i && ({1'b0, ps_if.target_pos_i} < P_EXT);
    assign w_tgt_inc  = (r_target == P_LAST) ? '0 : r_target + POS_W'(1);
    assign w_tgt_dec  = (r_target == '0) ? P_LAST : r_target - POS_W'(1);
    assign w_cur_inc  = (r_cur_pos == P_LAST) ? '0 : r_cur_pos + POS_W'(1);
    assign w_cur_dec  = (r_cur_pos == '0) ? P_LAST : r_cur_pos - POS_W'(1);
    assign w_cur_step = r_incdec ? w_cur_inc : w_cur_dec;

    // Next target: a load (valid or not) always suppresses a same-cycle step;
    // steps are refused while parked in ERR.
    always_comb begin
        w_target_nxt = r_target;
        if (w_load_ok) begin
            w_target_nxt = ps_if.target_pos_i;
        end else if (!ps_if.target_load_i && ps_if.step_req_i && (r_state != S_ERR)) begin
            w_target_nxt = ps_if.step_dir_i ? w_tgt_inc : w_tgt_dec;
        end
    end

    // Step sequencer with registered MMCM and status outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_target    <= '0;
            r_cur_pos   <= '0;
            r_cnt       <= '0;
            r_psen      <= 1'b0;
            r_incdec    <= 1'b0;
            r_busy      <= 1'b0;
            r_at_target <= 1'b0;
            r_error     <= 1'b0;
        end else if (!locked_i) begin
            // Phase reverts to zero on relock, so forget position and target.
            r_state     <= S_IDLE;
            r_target    <= '0;
            r_cur_pos   <= '0;
            r_cnt       <= '0;
            r_psen      <= 1'b0;
            r_busy      <= 1'b0;
            r_at_target <= 1'b1;
            r_error     <= 1'b0;
        end else begin
            r_target <= w_target_nxt;
            r_psen   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_target != r_cur_pos) begin
                        r_state     <= S_ISSUE;
                        r_psen      <= 1'b1;
                        r_incdec    <= w_go_inc;
                        r_busy      <= 1'b1;
                        r_at_target <= 1'b0;
                    end else begin
                        r_at_target <= (w_target_nxt == r_cur_pos);
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT_DONE;
                    r_cnt   <= '0;
                end
                S_WAIT_DONE: begin
                    if (ps_if.psdone_i) begin
                        r_cur_pos <= w_cur_step;
`ifdef PS_SETTLE_EN
                        r_state   <= S_SETTLE;
                        r_cnt     <= '0;
`else
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_at_target <= (w_target_nxt == w_cur_step);
`endif
                    end else if (r_cnt == TMO_LAST) begin
                        r_state <= S_ERR;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef PS_SETTLE_EN
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_at_target <= (w_target_nxt == r_cur_pos);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                S_ERR: begin
                    if (w_load_ok) begin
                        r_state     <= S_IDLE;
                        r_error     <= 1'b0;
                        r_at_target <= (ps_if.target_pos_i == r_cur_pos);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ps_if.psen_o      = r_psen;
    assign ps_if.psincdec_o  = r_incdec;
    assign ps_if.cur_pos_o   = r_cur_pos;
    assign ps_if.busy_o      = r_busy;
    assign ps_if.at_target_o = r_at_target;
    assign ps_if.error_o     = r_error;
    assign ps_if.state_dbg_o = r_state;

endmodule

// File: tb/tb_mmcm_phase_shift_ctrl.sv
// tb_mmcm_phase_shift_ctrl
// Directed bench for mmcm_phase_shift_ctrl with a PSDONE responder that answers
// 12 cycles after each PSEN, plus a PSEN pulse monitor.
`timescale 1ns/1ps

module tb_mmcm_phase_shift_ctrl;

    localparam int POS_W = 16;
    localparam int P     = 4480;
    localparam int TMO   = 64;
`ifdef PS_SETTLE_EN
    localparam int GAP = 12 + 16 + 2;
`else
    localparam int GAP = 12 + 2;
`endif

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic locked = 1'b0;
    always #5 clk = ~clk;

    mmcm_phase_shift_ctrl_if #(.POS_W(POS_W)) ps();

    mmcm_phase_shift_ctrl #(
        .POS_W(POS_W), .STEPS_PER_P(P), .DONE_TMO(TMO), .SETTLE_CYC(16)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .locked_i(locked),
        .ps_if   (ps)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   load_cyc = 0;
    int   pulse_cnt = 0;
    int   inc_cnt = 0;
    int   first_psen_cyc = -1;
    int   last_psen_cyc = -1;
    int   gap_min = 1000000;
    int   gap_max = 0;
    logic first_incdec = 1'b0;
    logic prev_psen = 1'b0;
    logic wide_pulse = 1'b0;
    logic psdone_en = 1'b1;
    logic spur = 1'b0;

    // ---------------- MMCM PSDONE model and PSEN monitor ----------------
    initial begin : psdone_model
        int dly;
        dly = 0;
        ps.psdone_i = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            ps.psdone_i = 1'b0;
            if (dly > 0) begin
                dly--;
                if (dly == 0) ps.psdone_i = 1'b1;
            end
            if (spur) ps.psdone_i = 1'b1;
            if (ps.psen_o === 1'b1) begin
                if (psdone_en) dly = 12;
                pulse_cnt++;
                if (ps.psincdec_o === 1'b1) inc_cnt++;
                if (prev_psen) wide_pulse = 1'b1;
                if (first_psen_cyc < 0) begin
                    first_psen_cyc = cyc;
                    first_incdec   = ps.psincdec_o;
                end else begin
                    if (cyc - last_psen_cyc < gap_min) gap_min = cyc - last_psen_cyc;
                    if (cyc - last_psen_cyc > gap_max) gap_max = cyc - last_psen_cyc;
                end
                last_psen_cyc = cyc;
            end
            prev_psen = ps.psen_o;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        pulse_cnt      = 0;
        inc_cnt        = 0;
        first_psen_cyc = -1;
        last_psen_cyc  = -1;
        gap_min        = 1000000;
        gap_max        = 0;
        wide_pulse     = 1'b0;
    endtask

    task automatic do_load(input logic [POS_W-1:0] pos);
        ps.target_pos_i  = pos;
        ps.target_load_i = 1'b1;
        load_cyc         = cyc;
        tick(1);
        ps.target_load_i = 1'b0;
    endtask

    task automatic do_step(input logic dir);
        ps.step_dir_i = dir;
        ps.step_req_i = 1'b1;
        tick(1);
        ps.step_req_i = 1'b0;
    endtask

    task automatic wait_settled(input string name, input int budget);
        int n;
        n = 0;
        while (!(ps.at_target_o === 1'b1 && ps.busy_o === 1'b0) && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_settle: not at target after %0d cycles, cur=%0d busy=%b", name, budget, ps.cur_pos_o, ps.busy_o);
        end
    endtask

    task automatic wait_pulses(input string name, input int num, input int budget);
        int n;
        n = 0;
        while (pulse_cnt < num && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (pulse_cnt < num) begin
            errors++;
            $display("FAIL %s_pulses: got %0d pulses, want at least %0d", name, pulse_cnt, num);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n  = 1'b0;
        locked = 1'b1;
        tick(3);
        checks++;
        if ({ps.psen_o, ps.psincdec_o, ps.busy_o, ps.at_target_o, ps.error_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got psen,incdec,busy,at,err=%b want 00000",
                     {ps.psen_o, ps.psincdec_o, ps.busy_o, ps.at_target_o, ps.error_o});
        end
        checks++;
        if (ps.cur_pos_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_cur: got %0d want 0", ps.cur_pos_o);
        end
        rst_n = 1'b1;
        tick(1);
        checks++;
        if (ps.at_target_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_at_target: got %b want 1", ps.at_target_o);
        end
        tick(5);
        checks++;
        if (pulse_cnt !== 0 || ps.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got pulses=%0d busy=%b want 0 0", pulse_cnt, ps.busy_o);
        end
    endtask

    task automatic test_load_inc();
        clear_mon();
        do_load(16'd3);
        wait_settled("load3", 300);
        checks++;
        if (first_psen_cyc - load_cyc !== 2) begin
            errors++;
            $display("FAIL load3_latency: got %0d want 2", first_psen_cyc - load_cyc);
        end
        checks++;
        if (pulse_cnt !== 3 || inc_cnt !== 3 || wide_pulse !== 1'b0) begin
            errors++;
            $display("FAIL load3_pulses: got n=%0d inc=%0d wide=%b want 3 3 0", pulse_cnt, inc_cnt, wide_pulse);
        end
        checks++;
        if (gap_min !== GAP || gap_max !== GAP) begin
            errors++;
            $display("FAIL load3_gap: got %0d..%0d want %0d", gap_min, gap_max, GAP);
        end
        checks++;
        if (ps.cur_pos_o !== 16'd3 || ps.at_target_o !== 1'b1 || ps.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL load3_final: got cur=%0d at=%b busy=%b want 3 1 0", ps.cur_pos_o, ps.at_target_o, ps.busy_o);
        end
    endtask

    task automatic test_wrap();
        do_load(16'd0);
        wait_settled("home", 300);
        clear_mon();
        do_load(16'd4479);
        wait_pulses("wrap_dec", 1, 10);
        tick(4);
        checks++;
        if (ps.psincdec_o !== 1'b0 || ps.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_hold: got incdec=%b busy=%b want 0 1", ps.psincdec_o, ps.busy_o);
        end
        wait_settled("wrap_dec", 200);
        checks++;
        if (pulse_cnt !== 1 || inc_cnt !== 0 || ps.cur_pos_o !== 16'd4479) begin
            errors++;
            $display("FAIL wrap_dec: got n=%0d inc=%0d cur=%0d want 1 0 4479", pulse_cnt, inc_cnt, ps.cur_pos_o);
        end
        clear_mon();
        do_step(1'b1);
        wait_settled("step_up", 200);
        checks++;
        if (pulse_cnt !== 1 || inc_cnt !== 1 || ps.cur_pos_o !== 16'd0) begin
            errors++;
            $display("FAIL step_up_wrap: got n=%0d inc=%0d cur=%0d want 1 1 0", pulse_cnt, inc_cnt, ps.cur_pos_o);
        end
        clear_mon();
        do_step(1'b0);
        wait_settled("step_dn", 200);
        checks++;
        if (pulse_cnt !== 1 || inc_cnt !== 0 || ps.cur_pos_o !== 16'd4479) begin
            errors++;
            $display("FAIL step_dn_wrap: got n=%0d inc=%0d cur=%0d want 1 0 4479", pulse_cnt, inc_cnt, ps.cur_pos_o);
        end
        do_step(1'b1);
        wait_settled("step_back", 200);
        checks++;
        if (ps.cur_pos_o !== 16'd0) begin
            errors++;
            $display("FAIL step_back: got cur=%0d want 0", ps.cur_pos_o);
        end
    endtask

    task automatic test_timeout();
        int n;
        int err_cyc;
        psdone_en = 1'b0;
        clear_mon();
        do_load(16'd5);
        wait_pulses("tmo", 1, 10);
        n = 0;
        while (ps.error_o !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        err_cyc = cyc;
        checks++;
        if (ps.error_o !== 1'b1 || ps.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_flag: got error=%b busy=%b want 1 0", ps.error_o, ps.busy_o);
        end
        checks++;
        if (err_cyc - first_psen_cyc !== TMO) begin
            errors++;
            $display("FAIL tmo_time: got %0d cycles want %0d", err_cyc - first_psen_cyc, TMO);
        end
        do_step(1'b1);
        tick(20);
        checks++;
        if (pulse_cnt !== 1 || ps.psen_o !== 1'b0 || ps.error_o !== 1'b1 || ps.cur_pos_o !== 16'd0) begin
            errors++;
            $display("FAIL tmo_parked: got n=%0d psen=%b err=%b cur=%0d want 1 0 1 0",
                     pulse_cnt, ps.psen_o, ps.error_o, ps.cur_pos_o);
        end
        psdone_en = 1'b1;
        do_load(16'd0);
        checks++;
        if (ps.error_o !== 1'b0 || ps.at_target_o !== 1'b1) begin
            errors++;
            $display("FAIL tmo_clear: got error=%b at=%b want 0 1", ps.error_o, ps.at_target_o);
        end
        tick(5);
        checks++;
        if (pulse_cnt !== 1) begin
            errors++;
            $display("FAIL tmo_after: got %0d pulses want 1", pulse_cnt);
        end
    endtask

    task automatic test_unlock();
        clear_mon();
        do_load(16'd100);
        wait_pulses("unlock", 3, 100);
        tick(2);
        checks++;
        if (ps.cur_pos_o !== 16'd2 || ps.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL unlock_pre: got cur=%0d busy=%b want 2 1", ps.cur_pos_o, ps.busy_o);
        end
        locked = 1'b0;
        tick(1);
        checks++;
        if (ps.psen_o !== 1'b0 || ps.busy_o !== 1'b0 || ps.cur_pos_o !== 16'd0 || ps.error_o !== 1'b0) begin
            errors++;
            $display("FAIL unlock_drop: got psen=%b busy=%b cur=%0d err=%b want 0 0 0 0",
                     ps.psen_o, ps.busy_o, ps.cur_pos_o, ps.error_o);
        end
        tick(30);
        checks++;
        if (pulse_cnt !== 3 || ps.cur_pos_o !== 16'd0) begin
            errors++;
            $display("FAIL unlock_hold: got n=%0d cur=%0d want 3 0", pulse_cnt, ps.cur_pos_o);
        end
        locked = 1'b1;
        tick(3);
        checks++;
        if (pulse_cnt !== 3 || ps.at_target_o !== 1'b1 || ps.cur_pos_o !== 16'd0) begin
            errors++;
            $display("FAIL unlock_relock: got n=%0d at=%b cur=%0d want 3 1 0", pulse_cnt, ps.at_target_o, ps.cur_pos_o);
        end
    endtask

    task automatic test_half_boundary();
        clear_mon();
        do_load(16'd2240);
        wait_pulses("half", 1, 10);
        checks++;
        if (first_incdec !== 1'b1) begin
            errors++;
            $display("FAIL half_dir: got incdec=%b want 1", first_incdec);
        end
        do_load(16'd0);
        wait_settled("half", 200);
        checks++;
        if (ps.cur_pos_o !== 16'd0 || pulse_cnt !== 2 || inc_cnt !== 1) begin
            errors++;
            $display("FAIL half_back: got cur=%0d n=%0d inc=%0d want 0 2 1", ps.cur_pos_o, pulse_cnt, inc_cnt);
        end
        clear_mon();
        do_load(16'd2241);
        wait_pulses("half_p1", 1, 10);
        checks++;
        if (first_incdec !== 1'b0) begin
            errors++;
            $display("FAIL half_p1_dir: got incdec=%b want 0", first_incdec);
        end
        do_load(16'd0);
        wait_settled("half_p1", 200);
        checks++;
        if (ps.cur_pos_o !== 16'd0 || pulse_cnt !== 2 || inc_cnt !== 1) begin
            errors++;
            $display("FAIL half_p1_back: got cur=%0d n=%0d inc=%0d want 0 2 1", ps.cur_pos_o, pulse_cnt, inc_cnt);
        end
    endtask

    task automatic test_range_collision();
        clear_mon();
        do_load(16'd4480);
        tick(5);
        do_load(16'hFFFF);
        tick(5);
        checks++;
        if (pulse_cnt !== 0 || ps.at_target_o !== 1'b1 || ps.cur_pos_o !== 16'd0) begin
            errors++;
            $display("FAIL range_ignore: got n=%0d at=%b cur=%0d want 0 1 0", pulse_cnt, ps.at_target_o, ps.cur_pos_o);
        end
        ps.target_pos_i  = 16'd2;
        ps.target_load_i = 1'b1;
        ps.step_req_i    = 1'b1;
        ps.step_dir_i    = 1'b1;
        tick(1);
        ps.target_load_i = 1'b0;
        ps.step_req_i    = 1'b0;
        wait_settled("collide", 300);
        checks++;
        if (ps.cur_pos_o !== 16'd2 || pulse_cnt !== 2) begin
            errors++;
            $display("FAIL collide: got cur=%0d n=%0d want 2 2", ps.cur_pos_o, pulse_cnt);
        end
        spur = 1'b1;
        tick(1);
        spur = 1'b0;
        tick(3);
        checks++;
        if (ps.cur_pos_o !== 16'd2 || ps.at_target_o !== 1'b1 || ps.busy_o !== 1'b0 || pulse_cnt !== 2) begin
            errors++;
            $display("FAIL spurious_done: got cur=%0d at=%b busy=%b n=%0d want 2 1 0 2",
                     ps.cur_pos_o, ps.at_target_o, ps.busy_o, pulse_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        do_load(16'd10);
        wait_pulses("b2b", 3, 100);
        do_step(1'b1);
        wait_settled("b2b", 600);
        checks++;
        if (ps.cur_pos_o !== 16'd11 || pulse_cnt !== 9 || inc_cnt !== 9 || wide_pulse !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final: got cur=%0d n=%0d inc=%0d wide=%b want 11 9 9 0",
                     ps.cur_pos_o, pulse_cnt, inc_cnt, wide_pulse);
        end
        checks++;
        if (gap_min !== GAP || gap_max !== GAP) begin
            errors++;
            $display("FAIL b2b_gap: got %0d..%0d want %0d", gap_min, gap_max, GAP);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin : main
        ps.target_pos_i  = '0;
        ps.target_load_i = 1'b0;
        ps.step_req_i    = 1'b0;
        ps.step_dir_i    = 1'b0;
        clear_mon();
        test_reset();
        test_load_inc();
        test_wrap();
        test_timeout();
        test_unlock();
        test_half_boundary();
        test_range_collision();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
